// File: rtl/fcvt_wb_queue.sv
// fcvt_wb_queue: in-order writeback buffer between the FCVT.W.S conversion stage and the integer regfile.
// Latency: a result pushed in cycle N can be written back in N+1 at the earliest; there is no bypass when empty.
// Backpressure: in_ready = !full, with no push-through when full; writeback drains only on wb_grant. Optional macro FCVT_FFLAGS_ACC_EN.
module fcvt_wb_queue #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  input  logic [RD_W-1:0]            in_rd,
  input  logic [4:0]                 in_flags,
  input  logic                       wb_grant,
  output logic                       wb_we,
  output logic [RD_W-1:0]            wb_rd,
  output logic [31:0]                wb_data,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       fflags_clr,
  output logic [4:0]                 fflags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [RD_W-1:0] mem_rd   [DEPTH];
  logic [31:0]     mem_data [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic accept;   // handshake completes (rd==0 results included)
  logic push;     // handshake with a real destination: enqueue
  logic pop;

  // Handshake and drain qualifiers come from registered state plus wb_grant only.
  always_comb begin
    in_ready = (count != FULL_CNT);
    accept   = in_valid && in_ready;
    push     = accept && (in_rd != '0);
    pop      = (count != '0) && wb_grant;
    wb_we    = pop;
    wb_rd    = mem_rd[rd_ptr];
    wb_data  = mem_data[rd_ptr];
  end

  // Storage write at the tail; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (push) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); occupancy tracks push minus pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FCVT_FFLAGS_ACC_EN
  logic [4:0] flags_q;
  logic [4:0] accepted_flags;

  // Flags of every accepted result are ORed in; a concurrent clear drops only the old value.
  always_comb begin
    accepted_flags = accept ? in_flags : 5'b0;
  end

  // Sticky fflags accumulator.
  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= (fflags_clr ? 5'b0 : flags_q) | accepted_flags;
  end

  assign fflags = flags_q;
`else
  // No accumulator in this build: flag inputs are deliberately ignored.
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{in_flags, fflags_clr};
  assign fflags = 5'b0;
`endif

endmodule

// File: tb/tb_fcvt_wb_queue.sv
module tb_fcvt_wb_queue;
  localparam int DEPTH = 4;
  localparam int RD_W  = 5;
`ifdef FCVT_FFLAGS_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic [RD_W-1:0]   in_rd;
  logic [4:0]        in_flags;
  logic              wb_grant;
  logic              wb_we;
  logic [RD_W-1:0]   wb_rd;
  logic [31:0]       wb_data;
  logic [$clog2(DEPTH):0] count;
  logic              fflags_clr;
  logic [4:0]        fflags;

  fcvt_wb_queue #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd), .in_flags(in_flags),
    .wb_grant(wb_grant), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .count(count), .fflags_clr(fflags_clr), .fflags(fflags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] dat;
    logic [4:0]  fl;
    logic        g;
    logic        clr;
    logic        e_rdy;
    logic        e_we;
    logic        chk_head;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    int          e_cnt;
    logic [4:0]  e_ff;   // value expected when the accumulator is built in
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [31:0] dat,
                              input logic [4:0] fl, input logic g, input logic clr,
                              input logic e_rdy, input logic e_we, input logic chk_head,
                              input logic [4:0] e_rd, input logic [31:0] e_dat,
                              input int e_cnt, input logic [4:0] e_ff);
    vec_t r;
    r.v = v; r.rd = rd; r.dat = dat; r.fl = fl; r.g = g; r.clr = clr;
    r.e_rdy = e_rdy; r.e_we = e_we; r.chk_head = chk_head; r.e_rd = e_rd; r.e_dat = e_dat;
    r.e_cnt = e_cnt; r.e_ff = e_ff;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] dat,
                       input logic [4:0] fl, input logic g, input logic clr);
    in_valid = v; in_rd = rd; in_data = dat; in_flags = fl; wb_grant = g; fflags_clr = clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'd9, 32'hDEAD_BEEF, 5'b11111, 1'b1, 1'b0);  // ignored during reset
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  // Reference model state for the random phase
  logic [RD_W-1:0] q_rd[$];
  logic [31:0]     q_dat[$];
  logic [4:0]      m_ff;

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Directed vector table: outputs are checked in the cycle the inputs are applied.
    //            v  rd    data          fl       g  clr rdy we hd rd    data          cnt ff
    vecs[0]  = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  0, 1, 5'd0, 32'h0,        0, 5'b00000);
    vecs[1]  = mk(1, 5'd3, 32'h7,        5'b0,    1, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b00000);
    vecs[2]  = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  1, 1, 5'd3, 32'h7,        1, 5'b00000);
    vecs[3]  = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b00000);
    vecs[4]  = mk(1, 5'd1, 32'h11,       5'b0,    0, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b00000);
    vecs[5]  = mk(1, 5'd2, 32'h12,       5'b0,    0, 0,  1,  0, 1, 5'd1, 32'h11,       1, 5'b00000);
    vecs[6]  = mk(1, 5'd4, 32'h13,       5'b0,    0, 0,  1,  0, 1, 5'd1, 32'h11,       2, 5'b00000);
    vecs[7]  = mk(1, 5'd5, 32'h14,       5'b0,    0, 0,  1,  0, 1, 5'd1, 32'h11,       3, 5'b00000);
    vecs[8]  = mk(1, 5'd6, 32'h15,       5'b0,    0, 0,  0,  0, 1, 5'd1, 32'h11,       4, 5'b00000);
    vecs[9]  = mk(1, 5'd7, 32'h16,       5'b0,    1, 0,  0,  1, 1, 5'd1, 32'h11,       4, 5'b00000);
    vecs[10] = mk(1, 5'd7, 32'h16,       5'b0,    0, 0,  1,  0, 1, 5'd2, 32'h12,       3, 5'b00000);
    vecs[11] = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  0,  1, 1, 5'd2, 32'h12,       4, 5'b00000);
    vecs[12] = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  1, 1, 5'd4, 32'h13,       3, 5'b00000);
    vecs[13] = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  1, 1, 5'd5, 32'h14,       2, 5'b00000);
    vecs[14] = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  1, 1, 5'd7, 32'h16,       1, 5'b00000);
    vecs[15] = mk(1, 5'd0, 32'hFFFF_FFFF,5'b10000,1, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b00000);
    vecs[16] = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b10000);
    vecs[17] = mk(1, 5'd0, 32'h1,        5'b00001,1, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b10000);
    vecs[18] = mk(1, 5'd0, 32'h2,        5'b10000,1, 1,  1,  0, 0, 5'd0, 32'h0,        0, 5'b10001);
    vecs[19] = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b10000);
    vecs[20] = mk(0, 5'd0, 32'h0,        5'b0,    1, 1,  1,  0, 0, 5'd0, 32'h0,        0, 5'b10000);
    vecs[21] = mk(0, 5'd0, 32'h0,        5'b0,    1, 0,  1,  0, 0, 5'd0, 32'h0,        0, 5'b00000);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rd, vecs[i].dat, vecs[i].fl, vecs[i].g, vecs[i].clr);
      #1;
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      check($sformatf("vec%0d wb_we", i),    64'(wb_we),    64'(vecs[i].e_we));
      check($sformatf("vec%0d count", i),    64'(count),    64'(vecs[i].e_cnt));
      check($sformatf("vec%0d fflags", i),   64'(fflags),   64'(ACC ? vecs[i].e_ff : 5'b0));
      if (vecs[i].chk_head) begin
        check($sformatf("vec%0d wb_rd", i),   64'(wb_rd),   64'(vecs[i].e_rd));
        check($sformatf("vec%0d wb_data", i), 64'(wb_data), 64'(vecs[i].e_dat));
      end
    end

    // Hand sequence: reset asserted mid-drain with 3 entries queued.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i + 10), 32'(i + 100), 5'b00100, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    #1;
    check("drain count3", 64'(count), 64'd3);
    check("drain head", 64'(wb_rd), 64'd10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset count", 64'(count), 64'd0);
    check("post-reset wb_we", 64'(wb_we), 64'd0);
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    check("post-reset fflags", 64'(fflags), 64'd0);

    // Hand sequence: in_valid held during reset must not enqueue.
    do_reset();
    @(negedge clk);
    #1;
    check("reset-push ignored count", 64'(count), 64'd0);
    check("reset-push ignored fflags", 64'(fflags), 64'd0);

    // Random phase against a queue-based reference model.
    q_rd.delete(); q_dat.delete(); m_ff = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic v, g, clr, rdy, acc, en_push, en_pop;
      logic [4:0] rd, fl;
      logic [31:0] dat;
      @(negedge clk);
      v   = ($urandom_range(0, 3) != 0);
      g   = (cyc % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      fl  = 5'($urandom_range(0, 31)) & (($urandom_range(0, 3) == 0) ? 5'b11111 : 5'b00000);
      dat = $urandom;
      drive(v, rd, dat, fl, g, clr);
      #1;
      rdy     = (q_rd.size() != DEPTH);
      acc     = v && rdy;
      en_pop  = (q_rd.size() != 0) && g;
      en_push = acc && (rd != 0);
      check("rnd in_ready", 64'(in_ready), 64'(rdy));
      check("rnd wb_we",    64'(wb_we),    64'(en_pop));
      check("rnd count",    64'(count),    64'(q_rd.size()));
      check("rnd fflags",   64'(fflags),   64'(m_ff));
      if (en_pop) begin
        check("rnd wb_rd",   64'(wb_rd),   64'(q_rd[0]));
        check("rnd wb_data", 64'(wb_data), 64'(q_dat[0]));
        void'(q_rd.pop_front());
        void'(q_dat.pop_front());
      end
      if (en_push) begin
        q_rd.push_back(rd);
        q_dat.push_back(dat);
      end
      if (ACC) m_ff = (clr ? 5'b0 : m_ff) | (acc ? fl : 5'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
